// File: rtl/output_slew_limiter.sv
// Output conditioning between the output-select MUX and the DAC register:
// offset, clamp to programmable rails, then slew-rate limit on a divided tick.
module output_slew_limiter #(
  parameter int DIV_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [15:0]      in,
  input  logic signed [15:0]      offset,
  input  logic signed [15:0]      lo,
  input  logic signed [15:0]      hi,
  input  logic        [15:0]      step,
  input  logic        [DIV_W-1:0] div,
  input  logic                    hold,
  output logic signed [15:0]      out,
  output logic                    sat_hi,
  output logic                    sat_lo,
  output logic                    lim_err,
  output logic                    slewing
);

  logic signed [15:0] target_q, target_d;
  logic               sat_hi_q, sat_hi_d;
  logic               sat_lo_q, sat_lo_d;
  logic               lim_err_q, lim_err_d;
  logic [DIV_W-1:0]   cnt_q, cnt_d;
  logic signed [15:0] out_q, out_d;
  logic               slewing_q, slewing_d;

  logic signed [16:0] sum;
  logic signed [16:0] lo_ext;
  logic signed [16:0] hi_ext;
  logic signed [16:0] diff;
  logic        [16:0] mag;
  logic               tick;

  // Sum and rails are compared at 17 bits so an overflowing sum clamps instead of wrapping.
  always_comb begin
    sum       = {in[15], in} + {offset[15], offset};
    lo_ext    = {lo[15], lo};
    hi_ext    = {hi[15], hi};
    target_d  = target_q;
    sat_hi_d  = 1'b0;
    sat_lo_d  = 1'b0;
    lim_err_d = 1'b0;
    if (lo > hi) begin
      lim_err_d = 1'b1;
    end else if (sum > hi_ext) begin
      target_d = hi;
      sat_hi_d = 1'b1;
    end else if (sum < lo_ext) begin
      target_d = lo;
      sat_lo_d = 1'b1;
    end else begin
      target_d = sum[15:0];
    end
  end

  // A counter left above a newly lowered div restarts at 0 without producing a tick.
  always_comb begin
    tick  = (cnt_q == div);
    cnt_d = cnt_q + 1'b1;
    if (tick || (cnt_q > div)) begin
      cnt_d = '0;
    end
  end

  always_comb begin
    diff      = {target_q[15], target_q} - {out_q[15], out_q};
    mag       = diff[16] ? -diff : diff;
    out_d     = out_q;
    if (tick && !hold) begin
      if ((step == 16'd0) || (mag <= {1'b0, step})) begin
        out_d = target_q;
      end else if (!diff[16]) begin
        out_d = out_q + step;
      end else begin
        out_d = out_q - step;
      end
    end
    slewing_d = (out_d != target_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      target_q  <= '0;
      sat_hi_q  <= 1'b0;
      sat_lo_q  <= 1'b0;
      lim_err_q <= 1'b0;
      cnt_q     <= '0;
      out_q     <= '0;
      slewing_q <= 1'b0;
    end else begin
      target_q  <= target_d;
      sat_hi_q  <= sat_hi_d;
      sat_lo_q  <= sat_lo_d;
      lim_err_q <= lim_err_d;
      cnt_q     <= cnt_d;
      out_q     <= out_d;
      slewing_q <= slewing_d;
    end
  end

  assign out     = out_q;
  assign sat_hi  = sat_hi_q;
  assign sat_lo  = sat_lo_q;
  assign lim_err = lim_err_q;
  assign slewing = slewing_q;

endmodule

// File: tb/tb_output_slew_limiter.sv
// Directed bench for output_slew_limiter: expectations are queued with a due
// cycle when stimulus is driven and compared at the falling edge of that cycle.
module tb_output_slew_limiter;

  logic               clk = 1'b0;
  logic               rst;
  logic signed [15:0] in, offset, lo, hi;
  logic        [15:0] step;
  logic        [15:0] div;
  logic               hold;
  logic signed [15:0] out;
  logic               sat_hi, sat_lo, lim_err, slewing;
  logic        [3:0]  flags;

  localparam logic [3:0] F_ALL  = 4'b1111;
  localparam logic [3:0] F_SAT  = 4'b1110;
  localparam logic [3:0] F_SLEW = 4'b0001;

  typedef struct {
    int          due;
    string       tag;
    bit          chk_out;
    logic [15:0] exp_out;
    logic [3:0]  mask;
    logic [3:0]  exp_flags;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fails = 0;

  output_slew_limiter #(.DIV_W(16)) dut (
    .clk     (clk),
    .rst     (rst),
    .in      (in),
    .offset  (offset),
    .lo      (lo),
    .hi      (hi),
    .step    (step),
    .div     (div),
    .hold    (hold),
    .out     (out),
    .sat_hi  (sat_hi),
    .sat_lo  (sat_lo),
    .lim_err (lim_err),
    .slewing (slewing)
  );

  assign flags = {sat_hi, sat_lo, lim_err, slewing};

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic apply_stimulus(input int i_in, input int i_off, input int i_lo,
                                input int i_hi, input int i_step, input int i_div,
                                input bit i_hold);
    in     = 16'(i_in);
    offset = 16'(i_off);
    lo     = 16'(i_lo);
    hi     = 16'(i_hi);
    step   = 16'(i_step);
    div    = 16'(i_div);
    hold   = i_hold;
  endtask

  task automatic expect_at(input int delay, input string tag, input bit chk_out,
                           input int e_out, input logic [3:0] mask,
                           input logic [3:0] e_flags);
    exp_t e;
    e.due       = cyc + delay;
    e.tag       = tag;
    e.chk_out   = chk_out;
    e.exp_out   = 16'(e_out);
    e.mask      = mask;
    e.exp_flags = e_flags;
    exp_q.push_back(e);
  endtask

  task automatic check_output(input exp_t e);
    if (e.chk_out) begin
      n_checks++;
      assert (out === e.exp_out) else begin
        n_fails++;
        $error("[TB] FAIL %s out: observed %0d expected %0d", e.tag,
               $signed(out), $signed(e.exp_out));
      end
    end
    if (e.mask != 4'b0000) begin
      n_checks++;
      assert ((flags & e.mask) === (e.exp_flags & e.mask)) else begin
        n_fails++;
        $error("[TB] FAIL %s flags{sat_hi,sat_lo,lim_err,slewing}: observed %b expected %b mask %b",
               e.tag, flags, e.exp_flags, e.mask);
      end
    end
  endtask

  always @(negedge clk) begin
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (exp_q[i].due == cyc) begin
        check_output(exp_q[i]);
        exp_q.delete(i);
      end else if (exp_q[i].due < cyc) begin
        n_checks++;
        n_fails++;
        $error("[TB] FAIL %s missed: observed due %0d expected at %0d", exp_q[i].tag,
               cyc, exp_q[i].due);
        exp_q.delete(i);
      end
    end
  end

  task automatic step_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    apply_stimulus(0, 0, 0, 0, 0, 0, 1'b0);
    step_cycles(1);
    expect_at(0, "reset", 1'b1, 0, F_ALL, 4'b0000);

    rst = 1'b0;
    apply_stimulus(1000, -200, -32768, 32767, 0, 0, 1'b0);
    expect_at(1, "pass_t1", 1'b1, 0, F_ALL, 4'b0000);
    expect_at(2, "pass_out", 1'b1, 800, F_ALL, 4'b0000);
    step_cycles(3);

    apply_stimulus(32000, 2000, -30000, 30000, 0, 0, 1'b0);
    expect_at(1, "clamp_hi_flag", 1'b0, 0, F_SAT, 4'b1000);
    expect_at(2, "clamp_hi_out", 1'b1, 30000, F_ALL, 4'b1000);
    step_cycles(3);

    apply_stimulus(-32768, -1000, -30000, 30000, 0, 0, 1'b0);
    expect_at(1, "clamp_lo_flag", 1'b0, 0, F_SAT, 4'b0100);
    expect_at(2, "clamp_lo_out", 1'b1, -30000, F_ALL, 4'b0100);
    step_cycles(3);

    apply_stimulus(0, 0, -32768, 32767, 0, 0, 1'b0);
    expect_at(2, "settle_zero", 1'b1, 0, F_ALL, 4'b0000);
    step_cycles(3);

    apply_stimulus(1000, 0, -32768, 32767, 300, 3, 1'b0);
    expect_at(2, "up_start", 1'b1, 0, F_SLEW, 4'b0001);
    expect_at(4, "up_300", 1'b1, 300, F_SLEW, 4'b0001);
    expect_at(7, "up_300_wait", 1'b1, 300, F_SLEW, 4'b0001);
    expect_at(8, "up_600", 1'b1, 600, F_SLEW, 4'b0001);
    expect_at(12, "up_900", 1'b1, 900, F_SLEW, 4'b0001);
    expect_at(16, "up_1000", 1'b1, 1000, F_SLEW, 4'b0000);
    step_cycles(16);

    apply_stimulus(0, 0, -32768, 32767, 300, 3, 1'b0);
    expect_at(2, "dn_start", 1'b1, 1000, F_SLEW, 4'b0001);
    expect_at(4, "dn_700", 1'b1, 700, F_SLEW, 4'b0001);
    expect_at(8, "dn_400", 1'b1, 400, F_SLEW, 4'b0001);
    expect_at(12, "dn_100", 1'b1, 100, F_SLEW, 4'b0001);
    expect_at(16, "dn_0", 1'b1, 0, F_SLEW, 4'b0000);
    step_cycles(16);

    apply_stimulus(1000, 0, -32768, 32767, 300, 3, 1'b0);
    expect_at(4, "hr_300", 1'b1, 300, F_SLEW, 4'b0001);
    expect_at(8, "hr_600", 1'b1, 600, F_SLEW, 4'b0001);
    step_cycles(8);
    apply_stimulus(1000, 0, -32768, 32767, 300, 3, 1'b1);
    expect_at(4, "hold_mid", 1'b1, 600, F_SLEW, 4'b0001);
    expect_at(9, "hold_end", 1'b1, 600, F_SLEW, 4'b0001);
    step_cycles(10);
    apply_stimulus(1000, 0, -32768, 32767, 300, 3, 1'b0);
    expect_at(1, "release_pre", 1'b1, 600, F_SLEW, 4'b0001);
    expect_at(2, "release_900", 1'b1, 900, F_SLEW, 4'b0001);
    expect_at(6, "release_1000", 1'b1, 1000, F_SLEW, 4'b0000);
    step_cycles(6);

    apply_stimulus(50, 0, -32768, 32767, 0, 0, 1'b0);
    expect_at(2, "pre_illegal", 1'b1, 50, F_ALL, 4'b0000);
    step_cycles(3);
    apply_stimulus(2000, 0, 100, -100, 0, 0, 1'b0);
    expect_at(1, "illegal_flag", 1'b1, 50, F_ALL, 4'b0010);
    expect_at(3, "illegal_hold", 1'b1, 50, F_ALL, 4'b0010);
    step_cycles(3);
    apply_stimulus(2000, 0, -100, -100, 0, 0, 1'b0);
    expect_at(1, "rails_restored", 1'b1, 50, F_SAT, 4'b1000);
    expect_at(2, "lo_eq_hi", 1'b1, -100, F_ALL, 4'b1000);
    step_cycles(3);

    apply_stimulus(0, 0, -32768, 32767, 0, 0, 1'b0);
    step_cycles(3);
    apply_stimulus(1000, 0, -32768, 32767, 300, 3, 1'b0);
    expect_at(4, "rr_300", 1'b1, 300, F_SLEW, 4'b0001);
    expect_at(8, "rr_600", 1'b1, 600, F_SLEW, 4'b0001);
    step_cycles(9);
    rst = 1'b1;
    expect_at(1, "rst_mid_slew", 1'b1, 0, F_ALL, 4'b0000);
    step_cycles(1);
    rst = 1'b0;
    expect_at(3, "restart_pre", 1'b1, 0, F_SLEW, 4'b0001);
    expect_at(4, "restart_300", 1'b1, 300, F_SLEW, 4'b0001);
    expect_at(8, "restart_600", 1'b1, 600, F_SLEW, 4'b0001);
    step_cycles(10);

    apply_stimulus(1000, 0, -32768, 32767, 300, 1, 1'b0);
    expect_at(1, "divchg_wrap", 1'b1, 600, F_SLEW, 4'b0001);
    expect_at(2, "divchg_wait", 1'b1, 600, F_SLEW, 4'b0001);
    expect_at(3, "divchg_900", 1'b1, 900, F_SLEW, 4'b0001);
    expect_at(5, "divchg_1000", 1'b1, 1000, F_SLEW, 4'b0000);
    step_cycles(6);

    n_checks++;
    assert (exp_q.size() == 0) else begin
      n_fails++;
      $error("[TB] FAIL scoreboard_drain: observed %0d pending expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
